// File: rtl/nb_update_scheduler.sv
// Delayed-write scheduler: "q <= #d value" requests are parked in a ring of MAXD slots
// and committed to q exactly d edges after acceptance. Optional macro: TSTAMP_EN.
module nb_update_scheduler #(
    parameter int DW   = 4,
    parameter int MAXD = 8,
    parameter int INIT = 4,
    parameter int CW   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [DW-1:0]              wr_data,
    input  logic [$clog2(MAXD+1)-1:0]  wr_delay,
    input  logic                       flush,
    output logic [DW-1:0]              q,
    output logic                       q_upd,
    output logic                       q_collide,
    output logic                       dly_err,
    output logic [$clog2(MAXD+1)-1:0]  pend_cnt
`ifdef TSTAMP_EN
    ,
    output logic [CW-1:0]              now,
    output logic [CW-1:0]              upd_time
`endif
);

    localparam int DLW = $clog2(MAXD + 1);
    localparam int HW  = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam logic [DLW:0] MAXD_W = (DLW + 1)'(MAXD);

    logic [HW-1:0]  head_reg;
    logic [MAXD-1:0] valid_reg;
    logic [MAXD-1:0] valid_next;
    logic [DW-1:0]  data_reg [MAXD];

    logic           dly_over;
    logic [DLW-1:0] d_eff;
    logic [DLW:0]   tsum;
    logic [HW-1:0]  target;
    logic           wr_now;
    logic           wr_slot;
    logic           commit;
    logic           collide;
    logic [DLW-1:0] cnt_next;

    // Request decode: clamp the delay and locate the ring slot it lands in.
    always_comb begin
        dly_over = (wr_delay > DLW'(MAXD));
        d_eff    = dly_over ? DLW'(MAXD) : wr_delay;
        tsum     = (DLW + 1)'(head_reg) + {1'b0, d_eff};
        target   = (tsum >= MAXD_W) ? HW'(tsum - MAXD_W) : HW'(tsum);
        wr_now   = wr_valid && (d_eff == '0);
        wr_slot  = wr_valid && (d_eff != '0);
        commit   = !flush && valid_reg[head_reg] && !wr_now;
        // The head slot is drained this edge, so landing on it is never a collision.
        collide  = wr_slot && !flush && valid_reg[target] && (target != head_reg);
    end

    // Slot occupancy: flush and drain first, then the new write (write beats clear).
    always_comb begin
        valid_next = valid_reg;
        cnt_next   = '0;
        for (int i = 0; i < MAXD; i++) begin
            if (flush || (head_reg == HW'(i))) begin
                valid_next[i] = 1'b0;
            end
            if (wr_slot && (target == HW'(i))) begin
                valid_next[i] = 1'b1;
            end
            cnt_next = cnt_next + DLW'(valid_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            valid_reg <= '0;
            q         <= DW'(INIT);
            q_upd     <= 1'b0;
            q_collide <= 1'b0;
            dly_err   <= 1'b0;
            pend_cnt  <= '0;
        end else begin
            head_reg  <= (head_reg == HW'(MAXD - 1)) ? '0 : head_reg + HW'(1);
            valid_reg <= valid_next;
            if (wr_now) begin
                q <= wr_data;
            end else if (commit) begin
                q <= data_reg[head_reg];
            end
            q_upd     <= wr_now || commit;
            q_collide <= collide;
            dly_err   <= wr_valid && dly_over;
            pend_cnt  <= cnt_next;
        end
    end

    // Payload storage needs no reset; the valid bits qualify every read.
    always_ff @(posedge clk) begin
        if (wr_slot) begin
            data_reg[target] <= wr_data;
        end
    end

`ifdef TSTAMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            now      <= '0;
            upd_time <= '0;
        end else begin
            now <= now + CW'(1);
            if (wr_now || commit) begin
                upd_time <= now;
            end
        end
    end
`else
    // CW only sizes the timestamp ports, which this build leaves out.
    localparam int unused_cw = CW;
`endif

endmodule

// File: tb/tb_nb_update_scheduler.sv
// Bench for nb_update_scheduler: directed scenarios then random traffic, checked against
// an absolute-time model (pending writes keyed by the edge number they are due on).
module tb_nb_update_scheduler;

    localparam int DW   = 4;
    localparam int MAXD = 8;
    localparam int INIT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic [3:0] wr_data = '0;
    logic [3:0] wr_delay = '0;
    logic       flush = 1'b0;
    logic [3:0] q;
    logic       q_upd;
    logic       q_collide;
    logic       dly_err;
    logic [3:0] pend_cnt;
`ifdef TSTAMP_EN
    logic [15:0] now;
    logic [15:0] upd_time;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [3:0] mq = 4'(INIT);
    logic [3:0] pend [int];
    int         n = 0;

    nb_update_scheduler #(.DW(DW), .MAXD(MAXD), .INIT(INIT), .CW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_delay  (wr_delay),
        .flush     (flush),
        .q         (q),
        .q_upd     (q_upd),
        .q_collide (q_collide),
        .dly_err   (dly_err),
        .pend_cnt  (pend_cnt)
`ifdef TSTAMP_EN
        ,
        .now       (now),
        .upd_time  (upd_time)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit eu, input bit ec, input bit ee);
        $display("%s: q=%0d upd=%0d col=%0d err=%0d pend=%0d", tag, q, q_upd, q_collide, dly_err, pend_cnt);
        check({tag, "/q"}, 32'(q), 32'(mq));
        check({tag, "/q_upd"}, 32'(q_upd), 32'(eu));
        check({tag, "/q_collide"}, 32'(q_collide), 32'(ec));
        check({tag, "/dly_err"}, 32'(dly_err), 32'(ee));
        check({tag, "/pend_cnt"}, 32'(pend_cnt), 32'(pend.num()));
    endtask

    // One clock edge with the given request; the model works in absolute edge numbers.
    task automatic step(input string tag, input bit wv, input logic [3:0] data,
                        input logic [3:0] dly, input bit fl);
        int  d;
        bit  eu;
        bit  ec;
        bit  ee;
        wr_valid = wv;
        wr_data  = data;
        wr_delay = dly;
        flush    = fl;
        @(posedge clk);
        d  = (int'(dly) > MAXD) ? MAXD : int'(dly);
        eu = 1'b0;
        ec = 1'b0;
        ee = wv && (int'(dly) > MAXD);
        if (fl) pend.delete();
        if (wv && d == 0) begin
            mq = data;
            eu = 1'b1;
        end else if (pend.exists(n)) begin
            mq = pend[n];
            eu = 1'b1;
        end
        if (pend.exists(n)) pend.delete(n);
        if (wv && d > 0) begin
            ec = pend.exists(n + d);
            pend[n + d] = data;
        end
        n++;
        #1;
        check_all(tag, eu, ec, ee);
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_delay = '0;
        flush    = 1'b0;
    endtask

    task automatic idle(input string tag, input int cnt);
        for (int i = 0; i < cnt; i++) step(tag, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges, checked before any clock edge.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        pend.delete();
        mq = 4'(INIT);
        check_all(tag, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        idle("idle_after_reset", 3);

        step("d0_data5", 1'b1, 4'd5, 4'd0, 1'b0);
        step("d3_data7", 1'b1, 4'd7, 4'd3, 1'b0);
        idle("wait_d3", 2);
        step("commit_d3", 1'b0, 4'd0, 4'd0, 1'b0);

        step("col_first", 1'b1, 4'd10, 4'd2, 1'b0);
        step("col_second", 1'b1, 4'd6, 4'd1, 1'b0);
        step("col_commit", 1'b0, 4'd0, 4'd0, 1'b0);

        step("maxd_pre", 1'b1, 4'd9, 4'd3, 1'b0);
        idle("maxd_wait", 2);
        step("maxd_write", 1'b1, 4'd3, 4'd8, 1'b0);
        idle("maxd_hold", 7);
        step("maxd_commit", 1'b0, 4'd0, 4'd0, 1'b0);

        step("flush_pre", 1'b1, 4'd2, 4'd4, 1'b0);
        idle("flush_gap", 1);
        step("flush", 1'b0, 4'd0, 4'd0, 1'b1);
        idle("post_flush", 3);

        step("flush_with_wr", 1'b1, 4'd12, 4'd2, 1'b1);
        step("flush_d0", 1'b1, 4'd1, 4'd0, 1'b1);
        idle("after_flush_wr", 2);

        step("dly15", 1'b1, 4'd11, 4'd15, 1'b0);
        idle("dly15_wait", 8);

        step("pre_rst", 1'b1, 4'd13, 4'd5, 1'b0);
        idle("pre_rst_idle", 1);
        do_reset("mid_rst");
        idle("after_mid_rst", 6);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset("rand_rst");
            end else begin
                step("rand",
                     ($urandom_range(9, 0) < 6),
                     4'($urandom_range(15, 0)),
                     4'($urandom_range(15, 0)),
                     ($urandom_range(15, 0) == 0));
            end
        end
        idle("drain", 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
